uart_rx_framer: RTL and testbench



---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_shift_reg.sv | 17 +
 rtl/uart_rx_framer.sv | 86 ++++++++
 tb/tb_uart_rx_framer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive and transmit blocks
package uart_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} rx_state_t;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD = 1'b1;
  localparam int DEFAULT_DATA_W = 8;
endpackage

// File: rtl/uart_shift_reg.sv
// uart_shift_reg: serial-in/parallel-out register; either end can receive the first bit
module uart_shift_reg #(
  parameter int DATA_W = uart_pkg::DEFAULT_DATA_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              din,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset || clear) q <= '0;
    else if (shift_en) q <= LSB_FIRST ? {din, q[DATA_W-1:1]} : {q[DATA_W-2:0], din};
  end
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: tick-driven UART receive framer with parity/stop checks and valid/ack output
module uart_rx_framer #(
  parameter int DATA_W = uart_pkg::DEFAULT_DATA_W,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_datain,
  input  logic              sample_tick,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] rx_dataout,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              rx_busy
);
  import uart_pkg::*;
  localparam logic [3:0] LAST = 4'(DATA_W - 1);
  rx_state_t state, state_n;
  logic [3:0] bit_cnt;
  logic armed, par_q, frm_q, start, shift_en, stop, done;
  logic [DATA_W-1:0] sh;
  uart_shift_reg #(.DATA_W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_sh (
    .clk(clk), .reset(reset), .shift_en(shift_en), .clear(start), .din(rx_datain), .q(sh)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (!rx_datain && armed) ? DATA : IDLE;
      DATA:    state_n = (bit_cnt == LAST) ? (PARITY_EN ? PARITY : STOP1) : DATA;
      PARITY:  state_n = STOP1;
      STOP1:   state_n = (STOP_BITS == 2) ? STOP2 : IDLE;
      default: state_n = IDLE;
    endcase
    if (!sample_tick) state_n = state;
    start = sample_tick && state == IDLE && !rx_datain && armed;
    shift_en = sample_tick && state == DATA;
    stop = sample_tick && (state == STOP1 || state == STOP2);
    done = stop && (state == STOP2 || STOP_BITS != 2);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      armed <= 1'b0;
      par_q <= 1'b0;
      frm_q <= 1'b0;
      rx_dataout <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      state <= state_n;
      rx_busy <= state_n != IDLE;
      if (start) begin
        bit_cnt <= '0;
        armed <= 1'b0;
        par_q <= 1'b0;
        frm_q <= 1'b0;
      end else if (shift_en) bit_cnt <= bit_cnt + 4'd1;
      if (sample_tick && state == IDLE && rx_datain) armed <= 1'b1;
      if (sample_tick && state == PARITY) par_q <= ^sh ^ rx_datain ^ PARITY_ODD;
      if (stop && !rx_datain) frm_q <= 1'b1;
      // completion wins over a plain ack; an ack alongside it only suppresses overrun
      if (done) begin
        rx_dataout <= sh;
        parity_err <= par_q;
        frame_err <= frm_q | !rx_datain;
        rx_valid <= 1'b1;
        overrun_err <= !rx_ack && (rx_valid || overrun_err);
        armed <= rx_datain;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        parity_err <= 1'b0;
        frame_err <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: scoreboard bench over four framer configurations sharing clock, reset and tick
module tb_uart_rx_framer;
  typedef struct packed {
    logic [1:0] inst;
    logic [8:0] d;
    logic pe;
    logic fe;
    logic ov;
  } exp_t;
  logic clk = 0, reset = 1, tick = 0, rst_q = 1;
  logic [3:0] rx = 4'hF, ack = 4'h0, bprev = 4'h0;
  wire [3:0] val, pe, fe, ov, busy;
  wire [7:0] dout_a, dout_b, dout_c;
  wire [6:0] dout_d;
  wire [8:0] got [4];
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  assign got[0] = {1'b0, dout_a};
  assign got[1] = {1'b0, dout_b};
  assign got[2] = {1'b0, dout_c};
  assign got[3] = {2'b0, dout_d};
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= reset;
  uart_rx_framer u_a (
    .clk(clk), .reset(reset), .rx_datain(rx[0]), .sample_tick(tick), .rx_ack(ack[0]),
    .rx_dataout(dout_a), .rx_valid(val[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .overrun_err(ov[0]), .rx_busy(busy[0])
  );
  uart_rx_framer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_b (
    .clk(clk), .reset(reset), .rx_datain(rx[1]), .sample_tick(tick), .rx_ack(ack[1]),
    .rx_dataout(dout_b), .rx_valid(val[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .overrun_err(ov[1]), .rx_busy(busy[1])
  );
  uart_rx_framer #(.STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset), .rx_datain(rx[2]), .sample_tick(tick), .rx_ack(ack[2]),
    .rx_dataout(dout_c), .rx_valid(val[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .overrun_err(ov[2]), .rx_busy(busy[2])
  );
  uart_rx_framer #(.DATA_W(7), .LSB_FIRST(1'b0)) u_d (
    .clk(clk), .reset(reset), .rx_datain(rx[3]), .sample_tick(tick), .rx_ack(ack[3]),
    .rx_dataout(dout_d), .rx_valid(val[3]), .parity_err(pe[3]), .frame_err(fe[3]),
    .overrun_err(ov[3]), .rx_busy(busy[3])
  );
  task automatic check(string nm, logic [31:0] g, logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask
  // a completed frame is the only way busy falls outside reset
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++)
      if (!rst_q && bprev[i] && !busy[i]) begin
        if (q.size() == 0) check("unexpected_word", {2'(i), got[i]}, 32'hFFFF_FFFF);
        else begin
          e = q.pop_front();
          check("word", {2'(i), got[i], pe[i], fe[i], ov[i], val[i]}, {e, 1'b1});
        end
      end
    bprev = busy;
  end
  task automatic tk(int i, logic b, logic a);
    @(negedge clk);
    rx[i] = b;
    tick = 1;
    ack[i] = a;
    @(negedge clk);
    tick = 0;
    ack[i] = 0;
    rx[i] = 1;
    @(negedge clk);
  endtask
  task automatic send(int i, logic [8:0] d, int w, bit lsb, bit par, logic pbit, int nstop,
                      logic [1:0] sv, bit ack_end);
    tk(i, 0, 0);
    for (int k = 0; k < w; k++) tk(i, lsb ? d[k] : d[w-1-k], 0);
    if (par) tk(i, pbit, 0);
    for (int k = 0; k < nstop; k++) tk(i, sv[k], ack_end && k == nstop - 1);
  endtask
  task automatic ack_pulse(int i);
    @(negedge clk);
    ack[i] = 1;
    @(negedge clk);
    ack[i] = 0;
  endtask
  task automatic push(int i, logic [8:0] d, logic p, logic f, logic o);
    q.push_back(exp_t'{2'(i), d, p, f, o});
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {val, pe, fe, ov, busy, dout_a}, 0);
    reset = 0;
    repeat (2) tk(0, 1, 0);
    push(0, 9'h0A5, 0, 0, 0);
    send(0, 9'h0A5, 8, 1, 0, 0, 1, 2'b01, 0);
    ack_pulse(0);
    check("ack_clears_valid", {31'b0, val[0]}, 0);
    push(1, 9'h05A, 1, 0, 0);
    send(1, 9'h05A, 8, 1, 1, 1, 1, 2'b01, 0);
    ack_pulse(1);
    push(1, 9'h05A, 0, 0, 0);
    send(1, 9'h05A, 8, 1, 1, 0, 1, 2'b01, 0);
    ack_pulse(1);
    push(2, 9'h03C, 0, 1, 0);
    send(2, 9'h03C, 8, 1, 0, 0, 2, 2'b01, 0);
    ack_pulse(2);
    for (int k = 0; k < 20; k++) tk(2, 0, 0);
    check("break_no_frame", {30'b0, busy[2], val[2]}, 0);
    tk(2, 1, 0);
    push(2, 9'h081, 0, 0, 0);
    send(2, 9'h081, 8, 1, 0, 0, 2, 2'b11, 0);
    ack_pulse(2);
    push(0, 9'h011, 0, 0, 0);
    send(0, 9'h011, 8, 1, 0, 0, 1, 2'b01, 0);
    push(0, 9'h022, 0, 0, 1);
    send(0, 9'h022, 8, 1, 0, 0, 1, 2'b01, 0);
    ack_pulse(0);
    check("ack_after_overrun", {22'b0, val[0], ov[0], dout_a}, 32'h22);
    push(0, 9'h033, 0, 0, 0);
    send(0, 9'h033, 8, 1, 0, 0, 1, 2'b01, 0);
    push(0, 9'h044, 0, 0, 0);
    send(0, 9'h044, 8, 1, 0, 0, 1, 2'b01, 1);
    ack_pulse(0);
    push(3, 9'h055, 0, 0, 0);
    send(3, 9'h055, 7, 0, 0, 0, 1, 2'b01, 0);
    ack_pulse(3);
    tk(0, 0, 0);
    for (int k = 0; k < 4; k++) tk(0, 1'(k), 0);
    check("midframe_busy", {31'b0, busy[0]}, 1);
    reset = 1;
    repeat (2) @(negedge clk);
    check("midframe_reset", {val, pe, fe, ov, busy, dout_a}, 0);
    reset = 0;
    repeat (2) tk(0, 1, 0);
    push(0, 9'h0C3, 0, 0, 0);
    send(0, 9'h0C3, 8, 1, 0, 0, 1, 2'b01, 0);
    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
